spell_sram_bridge: RTL and testbench
====================================

# spell_sram_bridge

Wishbone responder that terminates the spell core's shared-RAM bus (`rambus_wb_*`) and drives a single-port OpenRAM-style SRAM macro. It registers each classic-cycle request, converts it into one macro access with active-low chip/write selects and a byte mask, and returns data and a single-cycle `ack`. The macro read latency is configurable. The block sits between `spell_mem`'s SRAM master port and the macro instance in the top level.

## Interface
- `DEPTH`, 256: macro size in 32-bit words, 1..256.
- `READ_LATENCY`, 1: cycles from the macro sampling its select to `sram_dout_i` being valid, 1..3.
- `clock`  in  1  system clock, the same clock as `rambus_wb_clk_o`.
- `reset_n`  in  1  reset. Asynchronous, active-low.
- `wb_cyc_i`  in  1  cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  write enable.
- `wb_sel_i`  in  4  byte lane select. Bit n selects `wb_dat_i[8n+7:8n]`.
- `wb_addr_i`  in  10  byte address. Word index is `[9:2]`. `[1:0]` is ignored.
- `wb_dat_i`  in  32  write data.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `wb_dat_o`  out  32  read data.
- `sram_csb_o`  out  1  macro chip select, active-low.
- `sram_web_o`  out  1  macro write enable, active-low.
- `sram_wmask_o`  out  4  macro byte write mask.
- `sram_addr_o`  out  8  macro word address.
- `sram_din_o`  out  32  macro write data.
- `sram_dout_i`  in  32  macro read data.

## Operation
- States: IDLE, ACCESS, RWAIT, ACK, END.
- IDLE
  - When `wb_cyc_i && wb_stb_i`, latch `we`, `sel`, word address and data, then go to ACCESS.
  - Any other input leaves the state unchanged.
- ACCESS: drive the macro for exactly one cycle, using registered outputs.
  - Write with `sel != 0`: `csb=0`, `web=0`, `wmask=sel`, `din=data`. Next state ACK.
  - Write with `sel == 0`: `csb` stays 1 (no access). Next state ACK.
  - Read: `csb=0`, `web=1`. `sel` is ignored; a read always returns the full word. Next state RWAIT with latency counter = `READ_LATENCY`.
- RWAIT
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `sram_dout_i` into `wb_dat_o` and go to ACK.
- ACK
  - `wb_ack_o=1` for exactly one cycle, then go to END.
  - If `wb_cyc_i` was dropped at any point since the request was accepted, suppress the ack (abort). Read data is still captured.
- END: ignore requests for one cycle (master strobe turnaround), then go to IDLE.
- `wb_dat_o` holds the last captured read word. Writes do not change it.
- Outside ACCESS: `sram_csb_o=1`, `sram_web_o=1`, `sram_wmask_o=0`. `sram_addr_o` and `sram_din_o` hold their last values.
- A macro access that has started always completes. Dropping `cyc` never truncates `csb`.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). There is no ack for an in-flight request.

## Timing
- Reset values:
  - `wb_ack_o=0`, `wb_dat_o=0`
  - `sram_csb_o=1`, `sram_web_o=1`, `sram_wmask_o=0`, `sram_addr_o=0`, `sram_din_o=0`
  - state IDLE
- Request accepted in cycle 0. The macro is selected in cycle 1.
- Write ack in cycle 2.
- Read data and ack together in cycle `READ_LATENCY+2`.
- Back-to-back: the next request can be accepted no earlier than 2 cycles after its ack (END, then IDLE).
- A write therefore occupies 4 cycles and a read `READ_LATENCY+4` cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: `SPELL_SRAM_BRIDGE_RANGE_CHECK_EN`.
- Defined:
  - Word index `>= DEPTH` makes no macro access (`csb` stays 1 in ACCESS).
  - A read returns `32'hDEAD_BEEF`.
  - Ack timing is unchanged.
  - `DEPTH` may be any value from 1 to 256.
- Undefined:
  - The word index is truncated to `$clog2(DEPTH)` bits and wraps.
  - `DEPTH` must be a power of two.

## Test plan
- Full-word write: write `0x12345678` to byte address `0x010`, `sel=0xF` -> cycle 1 has `csb=0`, `web=0`, `addr=4`, `wmask=0xF`. `ack` is in cycle 2 only.
- Read, with `READ_LATENCY` 1, 2 and 3 and the macro model holding `0xCAFEF00D` at word 4: read `0x010` -> `ack` in cycle 3, 4 and 5 respectively, with `wb_dat_o=0xCAFEF00D`. `wb_dat_o` is unchanged by a following write.
- Byte-lane writes:
  - `sel=0x2`, data `0xAABBCCDD` -> `wmask=0x2`, and word bits `[15:8]` become `0xCC`.
  - `sel=0` -> `csb` never low, `ack` still in cycle 2.
- Abort: drop `wb_cyc_i` in cycle 2 of a `READ_LATENCY=3` read -> `csb` pulse is one full cycle, no ack, and a new request is accepted only after END.
- Reset: assert `reset_n=0` mid-RWAIT, asynchronous to `clock` -> all outputs at reset values before the next edge, no ack. After release, a write completes with ack in cycle 2.
- Range check, with the macro defined and `DEPTH=200`: read word 210 -> no `csb`, `wb_dat_o=0xDEADBEEF` with ack in cycle `READ_LATENCY+2`. Without the macro and with `DEPTH=128`: word 130 accesses `sram_addr_o=2`.

Source files
------------

// File: rtl/spell_sram_bridge.sv
// spell_sram_bridge: Wishbone classic-cycle responder for the spell core's
// shared-RAM bus, driving a single-port OpenRAM-style SRAM macro.
// Each accepted request becomes exactly one macro access. Reads return a
// full word after READ_LATENCY cycles. Every cycle is answered with a
// single-cycle ack, unless the master drops cyc, which aborts the cycle.
//
// Optional feature: define SPELL_SRAM_BRIDGE_RANGE_CHECK_EN to reject word
// indices >= DEPTH. With the check enabled, no macro access is made for such
// an index and a read returns 32'hDEAD_BEEF. With the macro undefined, the
// word index wraps modulo DEPTH, so DEPTH must then be a power of two.
`timescale 1ns/1ps

module spell_sram_bridge #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [9:0]  wb_addr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        sram_csb_o,
    output logic        sram_web_o,
    output logic [3:0]  sram_wmask_o,
    output logic [7:0]  sram_addr_o,
    output logic [31:0] sram_din_o,
    input  logic [31:0] sram_dout_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RWAIT,
        ST_ACK,
        ST_END
    } state_t;

    state_t      state_reg;
    logic        we_reg;
    logic        abort_reg;
    logic        oor_reg;
    logic [1:0]  lat_cnt_reg;

    logic [7:0]  word_idx;
    logic [7:0]  mapped_addr;
    logic        req_oor;
    logic        macro_sel;
    logic [31:0] read_word;

    // Byte-offset bits are not used; a word is always addressed as a whole.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^wb_addr_i[1:0];

    assign word_idx = wb_addr_i[9:2];

`ifdef SPELL_SRAM_BRIDGE_RANGE_CHECK_EN
    // Out-of-range indices are flagged. The macro is never selected for them.
    always_comb begin
        mapped_addr = word_idx;
        req_oor     = ({1'b0, word_idx} >= 9'(DEPTH));
        read_word   = oor_reg ? 32'hDEAD_BEEF : sram_dout_i;
    end
`else
    localparam logic [7:0] ADDR_MASK = 8'(DEPTH - 1);

    // Power-of-two DEPTH: keep only the low index bits, so addresses wrap.
    always_comb begin
        mapped_addr = word_idx & ADDR_MASK;
        req_oor     = 1'b0;
        read_word   = sram_dout_i;
    end
`endif

    // A request selects the macro unless it is an empty-mask write or out of range.
    assign macro_sel = !req_oor && (!wb_we_i || (wb_sel_i != 4'h0));

    // Request sequencing and all registered bus/macro outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            abort_reg    <= 1'b0;
            oor_reg      <= 1'b0;
            lat_cnt_reg  <= 2'd0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= 32'h0;
            sram_csb_o   <= 1'b1;
            sram_web_o   <= 1'b1;
            sram_wmask_o <= 4'h0;
            sram_addr_o  <= 8'h0;
            sram_din_o   <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        we_reg      <= wb_we_i;
                        abort_reg   <= 1'b0;
                        oor_reg     <= req_oor;
                        sram_addr_o <= mapped_addr;
                        sram_din_o  <= wb_dat_i;
                        if (macro_sel) begin
                            sram_csb_o   <= 1'b0;
                            sram_web_o   <= !wb_we_i;
                            sram_wmask_o <= wb_we_i ? wb_sel_i : 4'h0;
                        end
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // The macro is selected for exactly this one cycle, whatever cyc does.
                    sram_csb_o   <= 1'b1;
                    sram_web_o   <= 1'b1;
                    sram_wmask_o <= 4'h0;
                    if (we_reg) begin
                        wb_ack_o  <= wb_cyc_i;
                        state_reg <= ST_ACK;
                    end else begin
                        abort_reg   <= !wb_cyc_i;
                        lat_cnt_reg <= 2'(READ_LATENCY);
                        state_reg   <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (lat_cnt_reg == 2'd1) begin
                        // Data is captured even when the cycle was aborted.
                        wb_dat_o  <= read_word;
                        wb_ack_o  <= !abort_reg && wb_cyc_i;
                        state_reg <= ST_ACK;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                        abort_reg   <= abort_reg || !wb_cyc_i;
                    end
                end
                ST_ACK: begin
                    wb_ack_o  <= 1'b0;
                    state_reg <= ST_END;
                end
                ST_END: begin
                    // Strobe turnaround: a request still held from the last cycle is ignored.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_sram_bridge.sv
// Bench for spell_sram_bridge. Three instances, with READ_LATENCY 1, 2 and 3,
// share one Wishbone stimulus. Each instance has its own SRAM macro model.
// The model's read data is valid for exactly one cycle.
`timescale 1ns/1ps

module tb_spell_sram_bridge;

    localparam int N = 3;
`ifdef SPELL_SRAM_BRIDGE_RANGE_CHECK_EN
    localparam int TB_DEPTH = 200;
`else
    localparam int TB_DEPTH = 128;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [9:0]  adr;
    logic [31:0] dat;

    logic [N-1:0] ack_v, csb_v, web_v;
    logic [3:0]   wmask_a [N];
    logic [7:0]   addr_a  [N];
    logic [31:0]  din_a   [N];
    logic [31:0]  dato_a  [N];
    logic [31:0]  dout_a  [N];
    logic [31:0]  w4_a    [N];

    logic [31:0]  ack_m   [N];
    logic [31:0]  csb_m   [N];
    logic [7:0]   s_addr  [N];
    logic [3:0]   s_wmask [N];
    logic         s_web   [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int LAT = gi + 1;
            logic [31:0] mem  [256];
            logic [31:0] pipe [LAT];

            spell_sram_bridge #(
                .DEPTH(TB_DEPTH),
                .READ_LATENCY(LAT)
            ) u_dut (
                .clock       (clock),
                .reset_n     (reset_n),
                .wb_cyc_i    (cyc),
                .wb_stb_i    (stb),
                .wb_we_i     (we),
                .wb_sel_i    (sel),
                .wb_addr_i   (adr),
                .wb_dat_i    (dat),
                .wb_ack_o    (ack_v[gi]),
                .wb_dat_o    (dato_a[gi]),
                .sram_csb_o  (csb_v[gi]),
                .sram_web_o  (web_v[gi]),
                .sram_wmask_o(wmask_a[gi]),
                .sram_addr_o (addr_a[gi]),
                .sram_din_o  (din_a[gi]),
                .sram_dout_i (dout_a[gi])
            );

            initial begin
                for (int k = 0; k < 256; k++) mem[k] = 32'h0;
                for (int k = 0; k < LAT; k++) pipe[k] = 32'h0;
            end

            // Macro model: byte-masked write and a LAT-deep read pipeline.
            always @(posedge clock) begin
                if (!csb_v[gi] && !web_v[gi]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask_a[gi][b]) mem[addr_a[gi]][8*b +: 8] <= din_a[gi][8*b +: 8];
                end
                pipe[0] <= (!csb_v[gi] && web_v[gi]) ? mem[addr_a[gi]] : 32'h0;
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end

            assign dout_a[gi] = pipe[LAT-1];
            assign w4_a[gi]   = mem[4];
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Runs one request from cycle 0 for 12 cycles. Ack and csb activity is recorded
    // as per-cycle bitmasks. stb is held through cycle stb_last. cyc drops from
    // cycle drop_at on; a negative drop_at keeps cyc high.
    task automatic run_req(input logic w, input logic [3:0] s, input logic [9:0] a,
                           input logic [31:0] d, input int stb_last, input int drop_at);
        for (int i = 0; i < N; i++) begin
            ack_m[i] = 32'h0;
            csb_m[i] = 32'h0;
        end
        @(posedge clock); #1;
        we = w; sel = s; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (ack_v[i]) ack_m[i][k] = 1'b1;
                if (!csb_v[i]) begin
                    csb_m[i][k] = 1'b1;
                    s_addr[i]   = addr_a[i];
                    s_wmask[i]  = wmask_a[i];
                    s_web[i]    = web_v[i];
                end
            end
            @(posedge clock); #1;
            stb = (k + 1 <= stb_last);
            cyc = !(drop_at >= 0 && k + 1 >= drop_at);
        end
        cyc = 1'b0;
        stb = 1'b0;
        $display("txn we=%0b sel=%h adr=%h dat=%h ack_m=%h/%h/%h csb_m=%h/%h/%h",
                 w, s, a, d, ack_m[0], ack_m[1], ack_m[2], csb_m[0], csb_m[1], csb_m[2]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_ack%0d", tag, i),  32'(ack_v[i]),   32'h0);
            chk($sformatf("%s_dat%0d", tag, i),  dato_a[i],       32'h0);
            chk($sformatf("%s_csb%0d", tag, i),  32'(csb_v[i]),   32'h1);
            chk($sformatf("%s_web%0d", tag, i),  32'(web_v[i]),   32'h1);
            chk($sformatf("%s_wm%0d", tag, i),   32'(wmask_a[i]), 32'h0);
            chk($sformatf("%s_addr%0d", tag, i), 32'(addr_a[i]),  32'h0);
            chk($sformatf("%s_din%0d", tag, i),  din_a[i],        32'h0);
        end
    endtask

    initial begin
        logic [31:0] ack_seen;

        reset_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 10'h0; dat = 32'h0;
        #12;
        chk_reset_outputs("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Full-word write to word 4: macro selected in cycle 1, ack in cycle 2 only.
        run_req(1'b1, 4'hF, 10'h010, 32'h1234_5678, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wr_csb%0d", i),   csb_m[i],          32'h0000_0002);
            chk($sformatf("wr_ack%0d", i),   ack_m[i],          32'h0000_0004);
            chk($sformatf("wr_addr%0d", i),  32'(s_addr[i]),    32'h4);
            chk($sformatf("wr_wmask%0d", i), 32'(s_wmask[i]),   32'hF);
            chk($sformatf("wr_web%0d", i),   32'(s_web[i]),     32'h0);
            chk($sformatf("wr_mem%0d", i),   w4_a[i],           32'h1234_5678);
        end

        run_req(1'b1, 4'hF, 10'h010, 32'hCAFE_F00D, 0, -1);
        for (int i = 0; i < N; i++) chk($sformatf("wr2_mem%0d", i), w4_a[i], 32'hCAFE_F00D);

        // Read word 4: ack and data together in cycle READ_LATENCY+2.
        run_req(1'b0, 4'h1, 10'h010, 32'h0, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rd_csb%0d", i), csb_m[i],        32'h0000_0002);
            chk($sformatf("rd_ack%0d", i), ack_m[i],        32'd1 << (i + 3));
            chk($sformatf("rd_web%0d", i), 32'(s_web[i]),   32'h1);
            chk($sformatf("rd_dat%0d", i), dato_a[i],       32'hCAFE_F00D);
        end

        // Byte lane 1 only: mask 0x2, bits [15:8] become 0xCC, read data untouched.
        run_req(1'b1, 4'h2, 10'h010, 32'hAABB_CCDD, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bl_wmask%0d", i), 32'(s_wmask[i]), 32'h2);
            chk($sformatf("bl_ack%0d", i),   ack_m[i],        32'h0000_0004);
            chk($sformatf("bl_mem%0d", i),   w4_a[i],         32'hCAFE_CC0D);
            chk($sformatf("bl_dato%0d", i),  dato_a[i],       32'hCAFE_F00D);
        end

        // Empty-mask write: no macro access, ack still in cycle 2.
        run_req(1'b1, 4'h0, 10'h010, 32'h1111_1111, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("s0_csb%0d", i), csb_m[i], 32'h0);
            chk($sformatf("s0_ack%0d", i), ack_m[i], 32'h0000_0004);
            chk($sformatf("s0_mem%0d", i), w4_a[i],  32'hCAFE_CC0D);
        end

        run_req(1'b0, 4'hF, 10'h010, 32'h0, 0, -1);
        for (int i = 0; i < N; i++) chk($sformatf("rb_dat%0d", i), dato_a[i], 32'hCAFE_CC0D);

        // Strobe held: the second write is accepted in cycle 4, after END.
        run_req(1'b1, 4'hF, 10'h014, 32'h5A5A_5A5A, 4, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("b2b_csb%0d", i), csb_m[i], 32'h0000_0022);
            chk($sformatf("b2b_ack%0d", i), ack_m[i], 32'h0000_0044);
        end

        // Abort: cyc dropped in cycle 2. One-cycle csb, no ack, data still captured.
        run_req(1'b0, 4'hF, 10'h014, 32'h0, 0, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ab_csb%0d", i), csb_m[i],  32'h0000_0002);
            chk($sformatf("ab_ack%0d", i), ack_m[i],  32'h0);
            chk($sformatf("ab_dat%0d", i), dato_a[i], 32'h5A5A_5A5A);
        end

`ifdef SPELL_SRAM_BRIDGE_RANGE_CHECK_EN
        // Word 210 >= DEPTH 200: no macro access, DEADBEEF returned on time.
        run_req(1'b0, 4'hF, 10'h348, 32'h0, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("oor_csb%0d", i), csb_m[i],  32'h0);
            chk($sformatf("oor_ack%0d", i), ack_m[i],  32'd1 << (i + 3));
            chk($sformatf("oor_dat%0d", i), dato_a[i], 32'hDEAD_BEEF);
        end
        run_req(1'b1, 4'hF, 10'h348, 32'h1357_9BDF, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("oorw_csb%0d", i), csb_m[i], 32'h0);
            chk($sformatf("oorw_ack%0d", i), ack_m[i], 32'h0000_0004);
        end
`else
        // Word 130 with DEPTH 128 wraps to macro word 2.
        run_req(1'b1, 4'hF, 10'h208, 32'h0BAD_C0DE, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wrap_csb%0d", i),  csb_m[i],       32'h0000_0002);
            chk($sformatf("wrap_addr%0d", i), 32'(s_addr[i]), 32'h2);
        end
        run_req(1'b0, 4'hF, 10'h008, 32'h0, 0, -1);
        for (int i = 0; i < N; i++) chk($sformatf("wrap_rd%0d", i), dato_a[i], 32'h0BAD_C0DE);
`endif

        // Asynchronous reset in cycle 2, while every instance is in RWAIT.
        @(posedge clock); #1;
        we = 1'b0; sel = 4'hF; adr = 10'h010; cyc = 1'b1; stb = 1'b1;
        @(posedge clock); #1;
        stb = 1'b0;
        @(posedge clock); #1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        ack_seen = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) if (ack_v[i]) ack_seen[i] = 1'b1;
        end
        chk("arst_no_ack", ack_seen, 32'h0);
        cyc = 1'b0;
        reset_n = 1'b1;

        run_req(1'b1, 4'hF, 10'h010, 32'h7766_5544, 0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("post_ack%0d", i), ack_m[i], 32'h0000_0004);
            chk($sformatf("post_mem%0d", i), w4_a[i],  32'h7766_5544);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
